note_tone_gen: RTL and testbench

//  Downstream consumer of the controller's note_out/octave_auto: converts the 4-bit note code and
//  2-bit octave into a square wave on the board buzzer pin. Sits between the mode controller and
//  the speaker pad. Holds a note-change state machine and an optional silent articulation gap.

---
 rtl/music_pkg.sv | 44 ++++
 rtl/note_tone_gen_if.sv | 18 +
 rtl/note_period_lut.sv | 32 +++
 rtl/note_tone_gen.sv | 135 +++++++++++++
 tb/tb_note_tone_gen.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/music_pkg.sv
// Shared note/octave codes, FSM state encoding and the middle-octave half-period table
// used by the note_tone_gen slice.
package music_pkg;

   localparam logic [3:0] NOTE_REST = 4'd0;
   localparam logic [3:0] NOTE_DO   = 4'd1;
   localparam logic [3:0] NOTE_RE   = 4'd2;
   localparam logic [3:0] NOTE_MI   = 4'd3;
   localparam logic [3:0] NOTE_FA   = 4'd4;
   localparam logic [3:0] NOTE_SO   = 4'd5;
   localparam logic [3:0] NOTE_LA   = 4'd6;
   localparam logic [3:0] NOTE_SI   = 4'd7;

   localparam logic [1:0] OCT_MID  = 2'b00;
   localparam logic [1:0] OCT_HIGH = 2'b01;
   localparam logic [1:0] OCT_LOW  = 2'b10;

   // Middle-octave half periods in 100 MHz clock cycles
   localparam logic [31:0] HALF_DO = 32'd191113;
   localparam logic [31:0] HALF_RE = 32'd170262;
   localparam logic [31:0] HALF_MI = 32'd151686;
   localparam logic [31:0] HALF_FA = 32'd143173;
   localparam logic [31:0] HALF_SO = 32'd127551;
   localparam logic [31:0] HALF_LA = 32'd113636;
   localparam logic [31:0] HALF_SI = 32'd101239;

   typedef enum logic [1:0] {StIdle, StGap, StPlay} state_e;

   function automatic logic [31:0] mid_half(logic [3:0] note);
      logic [31:0] v;
      case (note)
         NOTE_DO: v = HALF_DO;
         NOTE_RE: v = HALF_RE;
         NOTE_MI: v = HALF_MI;
         NOTE_FA: v = HALF_FA;
         NOTE_SO: v = HALF_SO;
         NOTE_LA: v = HALF_LA;
         NOTE_SI: v = HALF_SI;
         default: v = 32'd0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/note_tone_gen_if.sv
// Note request in, square wave and sounding status out.
interface note_tone_gen_if;
   logic       enable;
   logic [3:0] note_in;
   logic [1:0] octave_in;
   logic       speaker;
   logic       sounding;

   modport master (
      output enable, note_in, octave_in,
      input  speaker, sounding
   );

   modport slave (
      input  enable, note_in, octave_in,
      output speaker, sounding
   );
endinterface

// File: rtl/note_period_lut.sv
// Combinational (note, octave) -> half period lookup. PERIOD_SHIFT scales the whole table
// down (0 = real pitch) so the wave can be observed over short runs.
module note_period_lut
   import music_pkg::*;
#(
   parameter int unsigned CNT_W        = 19,
   parameter int unsigned PERIOD_SHIFT = 0
) (
   input  logic [3:0]       i_note,
   input  logic [1:0]       i_octave,
   output logic [CNT_W-1:0] o_period,
   output logic             o_valid
);

   logic [31:0] w_base;
   logic [31:0] w_adj;

   assign w_base = mid_half(i_note) >> PERIOD_SHIFT;

   always_comb begin
      w_adj = w_base;
      case (i_octave)
         OCT_HIGH: w_adj = w_base >> 1;
         OCT_LOW:  w_adj = w_base << 1;
         default:  w_adj = w_base;
      endcase
   end

   assign o_period = CNT_W'(w_adj);
   assign o_valid  = (i_note >= NOTE_DO) && (i_note <= NOTE_SI);

endmodule

// File: rtl/note_tone_gen.sv
// Note code + octave -> buzzer square wave. Define TONE_GAP_EN to insert a silent gap of
// GAP_CYCLES before every new note; otherwise new notes start playing the next cycle.
module note_tone_gen
   import music_pkg::*;
#(
   parameter int unsigned CNT_W        = 19,
   parameter int unsigned GAP_CYCLES   = 5_000_000,
   parameter int unsigned PERIOD_SHIFT = 0
) (
   input  logic           clk,
   input  logic           reset,
   note_tone_gen_if.slave tone
);

   state_e           r_state,   w_state_d;
   logic [3:0]       r_note_q;
   logic [1:0]       r_octave_q;
   logic [CNT_W-1:0] r_period,  w_period_d;
   logic [CNT_W-1:0] r_cnt,     w_cnt_d;
   logic             r_speaker, w_speaker_d;
   logic [CNT_W-1:0] w_lut_period;
   logic             w_lut_valid;
   logic             w_change;
   logic             w_go;

   note_period_lut #(
      .CNT_W        (CNT_W),
      .PERIOD_SHIFT (PERIOD_SHIFT)
   ) u_lut (
      .i_note   (tone.note_in),
      .i_octave (tone.octave_in),
      .o_period (w_lut_period),
      .o_valid  (w_lut_valid)
   );

   assign w_change = {tone.note_in, tone.octave_in} != {r_note_q, r_octave_q};
   assign w_go     = tone.enable & w_lut_valid;

`ifdef TONE_GAP_EN
   localparam int unsigned    GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   logic [GAP_W-1:0] r_gap_cnt, w_gap_cnt_d;
`endif

   always_comb begin
      w_state_d   = r_state;
      w_period_d  = r_period;
      w_cnt_d     = r_cnt;
      w_speaker_d = r_speaker;
`ifdef TONE_GAP_EN
      w_gap_cnt_d = r_gap_cnt;
`endif
      // Disable/rest dominates every other transition, including a coincident note change
      if (!w_go) begin
         w_state_d   = StIdle;
         w_cnt_d     = '0;
         w_speaker_d = 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               w_period_d  = w_lut_period;
               w_cnt_d     = '0;
               w_speaker_d = 1'b0;
`ifdef TONE_GAP_EN
               w_state_d   = StGap;
               w_gap_cnt_d = '0;
`else
               w_state_d   = StPlay;
`endif
            end
            StGap: begin
`ifdef TONE_GAP_EN
               if (w_change) begin
                  w_period_d  = w_lut_period;
                  w_gap_cnt_d = '0;
               end else if (r_gap_cnt == GAP_LAST) begin
                  w_state_d   = StPlay;
                  w_cnt_d     = '0;
                  w_speaker_d = 1'b0;
               end else begin
                  w_gap_cnt_d = r_gap_cnt + 1'b1;
               end
`else
               w_state_d = StIdle;
`endif
            end
            StPlay: begin
               if (w_change) begin
                  w_period_d  = w_lut_period;
                  w_cnt_d     = '0;
                  w_speaker_d = 1'b0;
`ifdef TONE_GAP_EN
                  w_state_d   = StGap;
                  w_gap_cnt_d = '0;
`endif
               end else if (r_cnt == r_period - 1'b1) begin
                  w_cnt_d     = '0;
                  w_speaker_d = ~r_speaker;
               end else begin
                  w_cnt_d = r_cnt + 1'b1;
               end
            end
            default: w_state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= StIdle;
         r_note_q   <= NOTE_REST;
         r_octave_q <= OCT_MID;
         r_period   <= '0;
         r_cnt      <= '0;
         r_speaker  <= 1'b0;
`ifdef TONE_GAP_EN
         r_gap_cnt  <= '0;
`endif
      end else begin
         r_state    <= w_state_d;
         r_note_q   <= tone.note_in;
         r_octave_q <= tone.octave_in;
         r_period   <= w_period_d;
         r_cnt      <= w_cnt_d;
         r_speaker  <= w_speaker_d;
`ifdef TONE_GAP_EN
         r_gap_cnt  <= w_gap_cnt_d;
`endif
      end
   end

   assign tone.speaker  = r_speaker;
   assign tone.sounding = (r_state == StPlay);

endmodule

// File: tb/tb_note_tone_gen.sv
// Bench for note_tone_gen: full-scale period table vectors on the lookup, then directed and
// random stimulus on the top (periods scaled by SHIFT) against a phase-arithmetic model.
module tb_note_tone_gen;
   import music_pkg::*;

   localparam int unsigned GAP   = 16;
   localparam int unsigned SHIFT = 8;
`ifdef TONE_GAP_EN
   localparam int unsigned GAP_EXTRA = GAP;
   localparam bit          GAP_EN    = 1'b1;
`else
   localparam int unsigned GAP_EXTRA = 0;
   localparam bit          GAP_EN    = 1'b0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   note_tone_gen_if tone ();

   note_tone_gen #(
      .CNT_W        (19),
      .GAP_CYCLES   (GAP),
      .PERIOD_SHIFT (SHIFT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .tone  (tone)
   );

   logic [3:0]  lut_note;
   logic [1:0]  lut_oct;
   logic [18:0] lut_per;
   logic        lut_valid;

   note_period_lut #(
      .CNT_W        (19),
      .PERIOD_SHIFT (0)
   ) u_lut_full (
      .i_note   (lut_note),
      .i_octave (lut_oct),
      .o_period (lut_per),
      .o_valid  (lut_valid)
   );

   typedef struct {
      logic [3:0]  note;
      logic [1:0]  oct;
      int unsigned per;
      bit          valid;
   } lut_vec_t;

   int unsigned half_tab [8] = '{0, 191113, 170262, 151686, 143173, 127551, 113636, 101239};

   int total = 0;
   int bad   = 0;

   int unsigned cyc     = 0;
   int          m_mode  = 0;  // 0 idle, 1 gap, 2 play
   int unsigned m_start = 0;
   int unsigned m_per   = 1;
   logic [5:0]  m_prev  = '0;

   function automatic int unsigned exp_half(int unsigned note, int unsigned oct,
                                            int unsigned sh);
      int unsigned v;
      if (note < 1 || note > 7) return 0;
      v = half_tab[note] >> sh;
      if (oct == 1) v = v >> 1;
      else if (oct == 2) v = v << 1;
      return v;
   endfunction

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, act, exp);
      end
   endtask

   task automatic set_in(input logic en, input logic [3:0] note, input logic [1:0] oct);
      tone.enable    = en;
      tone.note_in   = note;
      tone.octave_in = oct;
   endtask

   // One clock: advance the model with the inputs the DUT sampled, then compare outputs
   task automatic step();
      bit          valid;
      bit          chg;
      int unsigned exp_spk;
      @(posedge clk);
      cyc++;
      valid = tone.enable && (tone.note_in >= 1) && (tone.note_in <= 7);
      chg   = {tone.note_in, tone.octave_in} != m_prev;
      if (reset) begin
         m_mode = 0;
         m_prev = '0;
      end else begin
         if (!valid) begin
            m_mode = 0;
         end else if (m_mode == 0 || chg) begin
            m_per   = exp_half(tone.note_in, tone.octave_in, SHIFT);
            m_start = cyc;
            m_mode  = GAP_EN ? 1 : 2;
         end else if (m_mode == 1 && cyc - m_start == GAP) begin
            m_mode  = 2;
            m_start = cyc;
         end
         m_prev = {tone.note_in, tone.octave_in};
      end
      #1;
      exp_spk = (m_mode == 2) ? ((cyc - m_start) / m_per) % 2 : 0;
      check("spk_snd", {tone.speaker, tone.sounding}, {exp_spk[0], m_mode == 2});
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Cycles until the next rising edge of speaker; returns budget on timeout
   task automatic wait_rise(input int unsigned budget, output int unsigned n);
      logic prev;
      n = 0;
      do begin
         prev = tone.speaker;
         step();
         n++;
      end while (!(tone.speaker && !prev) && n < budget);
   endtask

   initial begin
      lut_vec_t    lv [13];
      int unsigned n;
      int unsigned p;

      lv[0]  = '{4'd1,  2'd0, 191113, 1'b1};
      lv[1]  = '{4'd1,  2'd1, 95556,  1'b1};
      lv[2]  = '{4'd1,  2'd2, 382226, 1'b1};
      lv[3]  = '{4'd1,  2'd3, 191113, 1'b1};
      lv[4]  = '{4'd2,  2'd2, 340524, 1'b1};
      lv[5]  = '{4'd3,  2'd0, 151686, 1'b1};
      lv[6]  = '{4'd4,  2'd1, 71586,  1'b1};
      lv[7]  = '{4'd5,  2'd2, 255102, 1'b1};
      lv[8]  = '{4'd6,  2'd0, 113636, 1'b1};
      lv[9]  = '{4'd7,  2'd1, 50619,  1'b1};
      lv[10] = '{4'd0,  2'd0, 0,      1'b0};
      lv[11] = '{4'd9,  2'd2, 0,      1'b0};
      lv[12] = '{4'd15, 2'd1, 0,      1'b0};

      for (int i = 0; i < 13; i++) begin
         lut_note = lv[i].note;
         lut_oct  = lv[i].oct;
         #1;
         check("lut_valid", lut_valid, lv[i].valid);
         if (lv[i].valid) check("lut_period", lut_per, lv[i].per);
      end

      // Reset held with a valid note present
      set_in(1'b1, 4'd6, 2'd0);
      reset = 1'b1;
      steps(3);
      check("reset_speaker", tone.speaker, 0);
      check("reset_sounding", tone.sounding, 0);
      reset = 1'b0;

      // la middle: first rise one half period after entry, then three full periods
      p = 113636 >> SHIFT;
      wait_rise(10000, n);
      check("la_first_rise", n, 1 + GAP_EXTRA + p);
      for (int k = 0; k < 3; k++) begin
         wait_rise(10000, n);
         check("la_period", n, 2 * p);
      end

      // do high, then do low
      set_in(1'b1, 4'd1, 2'd1);
      wait_rise(10000, n);
      check("do_high_first", n, 1 + GAP_EXTRA + ((191113 >> SHIFT) >> 1));
      wait_rise(10000, n);
      check("do_high_period", n, 2 * ((191113 >> SHIFT) >> 1));
      set_in(1'b1, 4'd1, 2'd2);
      wait_rise(10000, n);
      check("do_low_first", n, 1 + GAP_EXTRA + ((191113 >> SHIFT) << 1));
      wait_rise(10000, n);
      check("do_low_period", n, 2 * ((191113 >> SHIFT) << 1));

      // mi -> so mid-tone, then a second change while the gap (if any) is running
      set_in(1'b1, 4'd3, 2'd0);
      wait_rise(10000, n);
      steps(20);
      set_in(1'b1, 4'd5, 2'd0);
      steps(5);
      set_in(1'b1, 4'd4, 2'd0);
      wait_rise(10000, n);
      check("gap_restart_rise", n, 1 + GAP_EXTRA + (143173 >> SHIFT));
      set_in(1'b1, 4'd5, 2'd0);
      wait_rise(10000, n);
      check("so_first_rise", n, 1 + GAP_EXTRA + (127551 >> SHIFT));

      // Out-of-range note, enable drop, and enable drop coincident with a note change
      set_in(1'b1, 4'd9, 2'd0);
      step();
      check("note9_idle", tone.sounding, 0);
      set_in(1'b1, 4'd6, 2'd0);
      wait_rise(10000, n);
      set_in(1'b0, 4'd6, 2'd0);
      step();
      check("en_low_speaker", tone.speaker, 0);
      set_in(1'b1, 4'd6, 2'd0);
      wait_rise(10000, n);
      set_in(1'b0, 4'd2, 2'd1);
      step();
      check("en_and_change_idle", tone.sounding, 0);
      steps(4);

      // Reset while the speaker is high; tone restarts from phase 0
      set_in(1'b1, 4'd7, 2'd0);
      wait_rise(10000, n);
      steps(10);
      reset = 1'b1;
      step();
      check("reset_mid_play", tone.speaker, 0);
      reset = 1'b0;
      wait_rise(10000, n);
      check("post_reset_rise", n, 1 + GAP_EXTRA + (101239 >> SHIFT));

      // Random segments
      for (int s = 0; s < 40; s++) begin
         logic [3:0] rn;
         rn = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(1, 7)) : 4'($urandom_range(0, 15));
         set_in($urandom_range(0, 9) != 0, rn, 2'($urandom_range(0, 3)));
         if ($urandom_range(0, 14) == 0) begin
            reset = 1'b1;
            step();
            reset = 1'b0;
         end
         steps($urandom_range(1, 600));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
